// File: rtl/lsu_mem_access_pkg.sv
// Shared definitions for the load/store access stage.
//   LSU_SIZE_*      : request size encodings (11 is handled as word)
//   lsu_state_e     : access sequencer states
//   lsu_size_mask   : byte-lane mask of an access before lane positioning
//   lsu_is_split    : true when an access crosses a word boundary
package lsu_mem_access_pkg;

   localparam logic [1:0] LSU_SIZE_B = 2'b00;
   localparam logic [1:0] LSU_SIZE_H = 2'b01;
   localparam logic [1:0] LSU_SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      LSU_IDLE   = 2'd0,
      LSU_FIRST  = 2'd1,
      LSU_SECOND = 2'd2,
      LSU_RESP   = 2'd3
   } lsu_state_e;

   function automatic logic [3:0] lsu_size_mask(input logic [1:0] size);
      case (size)
         LSU_SIZE_B: return 4'b0001;
         LSU_SIZE_H: return 4'b0011;
         default:    return 4'b1111;
      endcase
   endfunction

   // size[1] covers both the word encoding and the reserved 11
   function automatic logic lsu_is_split(input logic [1:0] size, input logic [1:0] off);
      return ((size == LSU_SIZE_H) && (off == 2'd3)) || (size[1] && (off != 2'd0));
   endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Request/response and RAM-side bundle of the load/store access stage.
//   slave  : the access stage (takes requests, drives the RAM)
//   master : execute stage plus data RAM (offers requests, returns read data)
interface lsu_mem_access_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid_i;
   logic              req_ready_o;
   logic              req_we_i;
   logic [1:0]        req_size_i;
   logic              req_unsigned_i;
   logic [ADDR_W-1:0] req_addr_i;
   logic [31:0]       req_wdata_i;
   logic              resp_valid_o;
   logic [31:0]       resp_rdata_o;
   logic [ADDR_W-1:0] ram_r_addr_o;
   logic              ram_w_en_o;
   logic [ADDR_W-1:0] ram_w_addr_o;
   logic [31:0]       ram_w_data_o;
   logic [3:0]        ram_w_sel_o;
   logic [31:0]       ram_r_data_i;

   modport slave (
      input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
             ram_r_data_i,
      output req_ready_o, resp_valid_o, resp_rdata_o,
             ram_r_addr_o, ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_w_sel_o
   );

   modport master (
      output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
             ram_r_data_i,
      input  req_ready_o, resp_valid_o, resp_rdata_o,
             ram_r_addr_o, ram_w_en_o, ram_w_addr_o, ram_w_data_o, ram_w_sel_o
   );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane alignment for the load/store access stage.
//   size, off, is_unsigned : captured request size, address offset, extension mode
//   wdata                  : right-justified store data
//   lo, hi                 : first / second RAM words of a load (hi = 0 if not split)
//   sel_first/data_first   : byte enables and data for the first word
//   sel_second/data_second : byte enables and data for the second word
//   rdata                  : aligned and extended load result
module lsu_lane_align
   import lsu_mem_access_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        is_unsigned,
   input  logic [31:0] wdata,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic [3:0]  sel_first,
   output logic [31:0] data_first,
   output logic [3:0]  sel_second,
   output logic [31:0] data_second,
   output logic [31:0] rdata
);
   logic [2:0]  back;
   logic [31:0] shifted;

   always_comb begin
      back        = 3'd4 - {1'b0, off};
      // 4-bit result: lanes pushed past bit 3 belong to the second word
      sel_first   = lsu_size_mask(size) << off;
      data_first  = wdata << {off, 3'b000};
      sel_second  = lsu_size_mask(size) >> back;
      data_second = wdata >> {back, 3'b000};
      shifted     = 32'({hi, lo} >> {off, 3'b000});
      case (size)
         LSU_SIZE_B: rdata = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
         LSU_SIZE_H: rdata = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
         default:    rdata = shifted;
      endcase
   end
endmodule

// File: rtl/lsu_mem_access.sv
// Load/store access stage in front of the data RAM. Accepts one request per
// handshake, issues one or two word accesses (two when the access crosses a
// word boundary) and returns a one-cycle response pulse with load data.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request/response handshake and RAM port (slave side)
module lsu_mem_access
   import lsu_mem_access_pkg::*;
#(
   parameter int unsigned ADDR_W = 32
)(
   input logic              clk,
   input logic              rst,
   lsu_mem_access_if.slave  bus
);
   lsu_state_e        state;
   logic              cap_we;
   logic              cap_uns;
   logic [1:0]        cap_size;
   logic [ADDR_W-1:0] cap_addr;
   logic [31:0]       cap_wdata;
   logic [31:0]       lo;
   logic              resp_valid;
   logic [31:0]       resp_rdata;

   logic [1:0]        off;
   logic              split;
   logic [ADDR_W-1:0] base;
   logic [ADDR_W-1:0] base_next;
   logic [31:0]       align_lo;
   logic [31:0]       align_hi;
   logic [31:0]       load_data;
   logic [3:0]        sel_first;
   logic [3:0]        sel_second;
   logic [31:0]       data_first;
   logic [31:0]       data_second;

   always_comb begin
      off       = cap_addr[1:0];
      split     = lsu_is_split(cap_size, off);
      base      = {cap_addr[ADDR_W-1:2], 2'b00};
      base_next = base + ADDR_W'(4);
      // The final word is fed straight from the RAM so the result is ready
      // on the edge that enters RESP; only the first word needs a register.
      align_lo  = (state == LSU_FIRST)  ? bus.ram_r_data_i : lo;
      align_hi  = (state == LSU_SECOND) ? bus.ram_r_data_i : '0;
   end

   lsu_lane_align u_align (
      .size        (cap_size),
      .off         (off),
      .is_unsigned (cap_uns),
      .wdata       (cap_wdata),
      .lo          (align_lo),
      .hi          (align_hi),
      .sel_first   (sel_first),
      .data_first  (data_first),
      .sel_second  (sel_second),
      .data_second (data_second),
      .rdata       (load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= LSU_IDLE;
         cap_we     <= 1'b0;
         cap_uns    <= 1'b0;
         cap_size   <= '0;
         cap_addr   <= '0;
         cap_wdata  <= '0;
         lo         <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state)
            LSU_IDLE: begin
               if (bus.req_valid_i) begin
                  cap_we    <= bus.req_we_i;
                  cap_uns   <= bus.req_unsigned_i;
                  cap_size  <= bus.req_size_i;
                  cap_addr  <= bus.req_addr_i;
                  cap_wdata <= bus.req_wdata_i;
                  state     <= LSU_FIRST;
               end
            end
            LSU_FIRST: begin
               lo <= bus.ram_r_data_i;
               if (split) begin
                  state <= LSU_SECOND;
               end else begin
                  state      <= LSU_RESP;
                  resp_valid <= 1'b1;
                  resp_rdata <= cap_we ? '0 : load_data;
               end
            end
            LSU_SECOND: begin
               state      <= LSU_RESP;
               resp_valid <= 1'b1;
               resp_rdata <= cap_we ? '0 : load_data;
            end
            LSU_RESP: state <= LSU_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.ram_r_addr_o = '0;
      bus.ram_w_addr_o = '0;
      bus.ram_w_en_o   = 1'b0;
      bus.ram_w_sel_o  = '0;
      bus.ram_w_data_o = '0;
      case (state)
         LSU_FIRST: begin
            bus.ram_r_addr_o = base;
            bus.ram_w_addr_o = base;
            if (cap_we) begin
               bus.ram_w_en_o  = 1'b1;
               bus.ram_w_sel_o = sel_first;
               bus.ram_w_data_o = data_first;
            end
         end
         LSU_SECOND: begin
            bus.ram_r_addr_o = base_next;
            bus.ram_w_addr_o = base_next;
            if (cap_we) begin
               bus.ram_w_en_o  = 1'b1;
               bus.ram_w_sel_o = sel_second;
               bus.ram_w_data_o = data_second;
            end
         end
         default: ;
      endcase
      // A reset arriving mid-access must not let the pending write land
      if (rst) bus.ram_w_en_o = 1'b0;
   end

   assign bus.req_ready_o  = (state == LSU_IDLE);
   assign bus.resp_valid_o = resp_valid;
   assign bus.resp_rdata_o = resp_rdata;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Self-checking bench for lsu_mem_access: a 1 KiB word RAM model wired to the
// RAM port, plus a byte-addressed reference memory used to predict load
// results and store effects.
module tb_lsu_mem_access;
   import lsu_mem_access_pkg::*;

   localparam int unsigned ADDR_W = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   lsu_mem_access_if #(.ADDR_W(ADDR_W)) bus();
   lsu_mem_access #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   // RAM: 256 words, indexed by address bits [9:2]
   logic [31:0] ram [0:255];
   logic        bd_we;
   logic [7:0]  bd_idx;
   logic [31:0] bd_data;

   always @(posedge clk) begin
      if (bd_we) begin
         ram[bd_idx] <= bd_data;
      end else if (bus.ram_w_en_o) begin
         for (int i = 0; i < 4; i++)
            if (bus.ram_w_sel_o[i]) ram[bus.ram_w_addr_o[9:2]][8*i +: 8] <= bus.ram_w_data_o[8*i +: 8];
      end
   end
   assign bus.ram_r_data_i = ram[bus.ram_r_addr_o[9:2]];

   // Reference: byte memory, address taken modulo 1024
   logic [7:0] mb [0:1023];
   int checks = 0;
   int errors = 0;

   // per-access observations from the last run_op
   logic [3:0]  obs_sel   [2];
   logic [31:0] obs_waddr [2];
   logic [31:0] obs_wdata [2];
   logic [31:0] obs_raddr [2];
   int          obs_wen;

   function automatic int nbytes(input logic [1:0] size);
      return (size == LSU_SIZE_B) ? 1 : (size == LSU_SIZE_H) ? 2 : 4;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [1:0] size, input logic uns, input logic [31:0] addr);
      logic [31:0] v;
      int n;
      n = nbytes(size);
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mb[10'(addr + 32'(i))];
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      return v;
   endfunction

   function automatic logic [31:0] mdl_word(input logic [7:0] idx);
      return {mb[{idx, 2'd3}], mb[{idx, 2'd2}], mb[{idx, 2'd1}], mb[{idx, 2'd0}]};
   endfunction

   task automatic bd_write(input logic [7:0] idx, input logic [31:0] data);
      @(negedge clk);
      bd_we = 1'b1; bd_idx = idx; bd_data = data;
      for (int k = 0; k < 4; k++) mb[{idx, 2'(k)}] = data[8*k +: 8];
      @(negedge clk);
      bd_we = 1'b0;
   endtask

   task automatic run_op(input string name, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] got, output int lat);
      logic [31:0] exp_rd;
      int          exp_lat;
      int          n;
      int          k;
      logic        spl;
      logic [7:0]  idx0;
      n      = nbytes(size);
      spl    = (int'(addr[1:0]) + n) > 4;
      exp_lat = spl ? 3 : 2;
      exp_rd = we ? 32'h0 : mdl_load(size, uns, addr);
      obs_wen = 0;
      obs_raddr[0] = 'x; obs_raddr[1] = 'x;
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = we; bus.req_size_i = size;
      bus.req_unsigned_i = uns; bus.req_addr_i = addr; bus.req_wdata_i = wdata;
      k = 0;
      while (!bus.req_ready_o && k < 8) begin @(negedge clk); k++; end
      checks++;
      if (!bus.req_ready_o) begin
         errors++;
         $display("FAIL %s ready: got 0 required 1", name);
         bus.req_valid_i = 1'b0;
         got = 'x; lat = 0;
         return;
      end
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      bus.req_we_i = 1'($urandom); bus.req_size_i = 2'($urandom);
      bus.req_addr_i = $urandom; bus.req_wdata_i = $urandom; bus.req_unsigned_i = 1'($urandom);
      lat = 1;
      while (!bus.resp_valid_o && lat < 8) begin
         if (lat <= 2) obs_raddr[lat-1] = bus.ram_r_addr_o;
         if (bus.ram_w_en_o) begin
            if (obs_wen < 2) begin
               obs_sel[obs_wen] = bus.ram_w_sel_o;
               obs_waddr[obs_wen] = bus.ram_w_addr_o;
               obs_wdata[obs_wen] = bus.ram_w_data_o;
            end
            obs_wen++;
         end
         @(negedge clk); lat++;
      end
      got = bus.resp_rdata_o;
      checks++;
      if (lat != exp_lat || !bus.resp_valid_o) begin
         errors++; $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
      end
      checks++;
      if (got !== exp_rd) begin
         errors++; $display("FAIL %s rdata: got %h required %h", name, got, exp_rd);
      end
      checks++;
      if (obs_wen != (we ? (spl ? 2 : 1) : 0)) begin
         errors++; $display("FAIL %s w_en cycles: got %0d required %0d", name, obs_wen, we ? (spl ? 2 : 1) : 0);
      end
      checks++;
      if (obs_raddr[0] !== (addr & ~32'h3)) begin
         errors++; $display("FAIL %s first r_addr: got %h required %h", name, obs_raddr[0], addr & ~32'h3);
      end
      if (spl) begin
         checks++;
         if (obs_raddr[1] !== (addr & ~32'h3) + 32'h4) begin
            errors++; $display("FAIL %s second r_addr: got %h required %h", name, obs_raddr[1], (addr & ~32'h3) + 32'h4);
         end
      end
      if (we) for (int i = 0; i < n; i++) mb[10'(addr + 32'(i))] = wdata[8*i +: 8];
      idx0 = addr[9:2];
      for (int w = 0; w < 2; w++) begin
         checks++;
         if (ram[idx0 + 8'(w)] !== mdl_word(idx0 + 8'(w))) begin
            errors++; $display("FAIL %s ram word %0d: got %h required %h", name, w, ram[idx0 + 8'(w)], mdl_word(idx0 + 8'(w)));
         end
      end
      @(negedge clk);
      checks++;
      if (bus.resp_valid_o !== 1'b0) begin
         errors++; $display("FAIL %s resp pulse width: got 1 required 0", name);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int unsigned i = 0; i < 256; i++) bd_write(8'(i), $urandom);
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL reset ready: got %b required 1", bus.req_ready_o); end
      checks++; if (bus.resp_valid_o !== 1'b0) begin errors++; $display("FAIL reset resp_valid: got %b required 0", bus.resp_valid_o); end
      checks++; if (bus.resp_rdata_o !== 32'h0) begin errors++; $display("FAIL reset resp_rdata: got %h required 0", bus.resp_rdata_o); end
      checks++;
      if ({bus.ram_w_en_o, bus.ram_w_sel_o, bus.ram_r_addr_o, bus.ram_w_addr_o, bus.ram_w_data_o} !== '0) begin
         errors++; $display("FAIL reset ram outputs: got en=%b sel=%b ra=%h wa=%h wd=%h required all 0",
                             bus.ram_w_en_o, bus.ram_w_sel_o, bus.ram_r_addr_o, bus.ram_w_addr_o, bus.ram_w_data_o);
      end
   endtask

   task automatic test_plan();
      logic [31:0] got;
      int lat;
      bd_write(8'h40, 32'h44332211);
      bd_write(8'h41, 32'h88776655);
      run_op("st_word", 1'b1, LSU_SIZE_W, 1'b0, 32'h100, 32'hDEADBEEF, got, lat);
      checks++; if (obs_sel[0] !== 4'b1111) begin errors++; $display("FAIL st_word sel: got %b required 1111", obs_sel[0]); end
      checks++; if (obs_waddr[0] !== 32'h100) begin errors++; $display("FAIL st_word w_addr: got %h required 100", obs_waddr[0]); end
      checks++; if (ram[8'h40] !== 32'hDEADBEEF) begin errors++; $display("FAIL st_word ram: got %h required deadbeef", ram[8'h40]); end
      bd_write(8'h40, 32'h44332211);
      run_op("ld_byte_s", 1'b0, LSU_SIZE_B, 1'b0, 32'h107, 32'h0, got, lat);
      checks++; if (got !== 32'hFFFFFF88) begin errors++; $display("FAIL ld_byte_s const: got %h required ffffff88", got); end
      run_op("ld_byte_u", 1'b0, LSU_SIZE_B, 1'b1, 32'h107, 32'h0, got, lat);
      checks++; if (got !== 32'h00000088) begin errors++; $display("FAIL ld_byte_u const: got %h required 00000088", got); end
      run_op("ld_half_s", 1'b0, LSU_SIZE_H, 1'b0, 32'h102, 32'h0, got, lat);
      checks++; if (got !== 32'h00004433) begin errors++; $display("FAIL ld_half_s const: got %h required 00004433", got); end
      run_op("ld_word_split", 1'b0, LSU_SIZE_W, 1'b0, 32'h103, 32'h0, got, lat);
      checks++; if (got !== 32'h77665544 || lat != 3) begin errors++; $display("FAIL ld_word_split const: got %h lat %0d required 77665544 lat 3", got, lat); end
      run_op("st_half_split", 1'b1, LSU_SIZE_H, 1'b0, 32'h103, 32'h0000ABCD, got, lat);
      checks++;
      if (obs_sel[0] !== 4'b1000 || obs_wdata[0] !== 32'hCD000000 || obs_waddr[0] !== 32'h100) begin
         errors++; $display("FAIL st_half first: got sel %b data %h addr %h required 1000 cd000000 100", obs_sel[0], obs_wdata[0], obs_waddr[0]);
      end
      checks++;
      if (obs_sel[1] !== 4'b0001 || obs_wdata[1] !== 32'h000000AB || obs_waddr[1] !== 32'h104) begin
         errors++; $display("FAIL st_half second: got sel %b data %h addr %h required 0001 000000ab 104", obs_sel[1], obs_wdata[1], obs_waddr[1]);
      end
      checks++;
      if (ram[8'h40] !== 32'hCD332211 || ram[8'h41] !== 32'h887766AB) begin
         errors++; $display("FAIL st_half ram: got %h %h required cd332211 887766ab", ram[8'h40], ram[8'h41]);
      end
   endtask

   task automatic test_reset_mid_split();
      logic seen_resp;
      logic [31:0] wd;
      bd_write(8'h40, 32'h44332211);
      bd_write(8'h41, 32'h88776655);
      wd = 32'h11223344;
      seen_resp = 1'b0;
      @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = LSU_SIZE_W;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h101; bus.req_wdata_i = wd;
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      seen_resp |= bus.resp_valid_o;
      @(negedge clk);
      seen_resp |= bus.resp_valid_o;
      checks++;
      if (bus.ram_r_addr_o !== 32'h104) begin errors++; $display("FAIL rst_mid in second: got r_addr %h required 104", bus.ram_r_addr_o); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen_resp |= bus.resp_valid_o;
      for (int i = 0; i < 3; i++) mb[10'(32'h101 + 32'(i))] = wd[8*i +: 8];
      @(negedge clk);
      seen_resp |= bus.resp_valid_o;
      checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL rst_mid ready: got %b required 1", bus.req_ready_o); end
      @(negedge clk);
      seen_resp |= bus.resp_valid_o;
      checks++; if (seen_resp !== 1'b0) begin errors++; $display("FAIL rst_mid resp_valid: got 1 required 0"); end
      checks++;
      if (ram[8'h40] !== mdl_word(8'h40) || ram[8'h41] !== mdl_word(8'h41)) begin
         errors++; $display("FAIL rst_mid ram: got %h %h required %h %h", ram[8'h40], ram[8'h41], mdl_word(8'h40), mdl_word(8'h41));
      end
      checks++;
      if (ram[8'h40] !== 32'h22334411 || ram[8'h41] !== 32'h88776655) begin
         errors++; $display("FAIL rst_mid ram const: got %h %h required 22334411 88776655", ram[8'h40], ram[8'h41]);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_a, exp_b;
      int low_cnt;
      bd_write(8'hFF, $urandom);
      bd_write(8'h00, $urandom);
      exp_a = mdl_load(LSU_SIZE_W, 1'b0, 32'hFFFFFFFE);
      exp_b = mdl_load(LSU_SIZE_B, 1'b1, 32'h00000002);
      low_cnt = 0;
      @(negedge clk);
      checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b idle ready: got 0 required 1"); end
      bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = LSU_SIZE_W;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'hFFFFFFFE; bus.req_wdata_i = '0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (!bus.req_ready_o) low_cnt++;
         if (c == 1) begin
            checks++;
            if (bus.ram_r_addr_o !== 32'hFFFFFFFC) begin errors++; $display("FAIL b2b first addr: got %h required fffffffc", bus.ram_r_addr_o); end
            bus.req_we_i = 1'b1; bus.req_addr_i = $urandom; bus.req_size_i = 2'($urandom);
         end
         if (c == 2) begin
            checks++;
            if (bus.ram_r_addr_o !== 32'h0) begin errors++; $display("FAIL b2b wrap addr: got %h required 00000000", bus.ram_r_addr_o); end
         end
         if (c == 3) begin
            checks++;
            if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== exp_a) begin
               errors++; $display("FAIL b2b resp a: got v=%b %h required v=1 %h", bus.resp_valid_o, bus.resp_rdata_o, exp_a);
            end
            bus.req_we_i = 1'b0; bus.req_size_i = LSU_SIZE_B; bus.req_unsigned_i = 1'b1; bus.req_addr_i = 32'h2;
         end
      end
      checks++; if (low_cnt != 3) begin errors++; $display("FAIL b2b ready low cycles: got %0d required 3", low_cnt); end
      @(negedge clk);
      checks++; if (bus.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b idle return: got ready 0 required 1"); end
      @(negedge clk);
      bus.req_valid_i = 1'b0;
      checks++; if (bus.req_ready_o !== 1'b0) begin errors++; $display("FAIL b2b second accept: got ready 1 required 0"); end
      @(negedge clk);
      checks++;
      if (bus.resp_valid_o !== 1'b1 || bus.resp_rdata_o !== exp_b) begin
         errors++; $display("FAIL b2b resp b: got v=%b %h required v=1 %h", bus.resp_valid_o, bus.resp_rdata_o, exp_b);
      end
   endtask

   task automatic test_random();
      logic [31:0] got;
      int lat;
      for (int unsigned i = 0; i < 80; i++) begin
         run_op("random", 1'($urandom), 2'($urandom), 1'($urandom),
                32'($urandom_range(0, 1023)), $urandom, got, lat);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      bd_we = 1'b0; bd_idx = '0; bd_data = '0;
      bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = '0;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
      test_reset();
      test_plan();
      test_reset_mid_split();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
